// File: rtl/dsc_mul_seq_if.sv
// dsc_mul_seq_if: start/abort/operand/result bundle for the DSC multiplier
interface dsc_mul_seq_if #(parameter int WIDTH = 10);
  logic start;
  logic abort;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [2*WIDTH-1:0] z;
  modport master(output start, abort, a, b, input busy, done, z);
  modport slave(input start, abort, a, b, output busy, done, z);
endinterface

// File: rtl/dsc_mul_seq.sv
// dsc_mul_seq: deterministic stochastic-computing multiplier, z = a*b by counting ANDed comparator streams
module dsc_mul_seq #(
  parameter int WIDTH = 10,
  parameter int EARLY_TERM = 0
) (
  input logic clk,
  input logic rst,
  dsc_mul_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [WIDTH-1:0] MAX = '1;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, ctr_a_q, ctr_a_d, ctr_b_q, ctr_b_d;
  logic [2*WIDTH-1:0] z_q, z_d;
  logic busy_q, busy_d, done_q, done_d;
  logic accept, hit, last;
  // B's counter is a clock-enabled slow counter stepping once per full A period
  always_comb begin
    accept = state_q != RUN && bus.start;
    hit = ctr_a_q < a_q && ctr_b_q < b_q;
    last = ctr_a_q == MAX && ctr_b_q == (EARLY_TERM != 0 ? b_q - 1'b1 : MAX);
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    ctr_a_d = ctr_a_q;
    ctr_b_d = ctr_b_q;
    z_d = z_q;
    if (accept) begin
      a_d = bus.a;
      b_d = bus.b;
      ctr_a_d = '0;
      ctr_b_d = '0;
      z_d = '0;
      state_d = (EARLY_TERM != 0 && bus.b == '0) ? DONE : RUN;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (state_q == RUN && bus.abort) begin
      state_d = IDLE;
      z_d = '0;
    end else if (state_q == RUN) begin
      z_d = z_q + (2*WIDTH)'(hit);
      ctr_a_d = ctr_a_q + 1'b1;
      ctr_b_d = ctr_a_q == MAX ? ctr_b_q + 1'b1 : ctr_b_q;
      state_d = last ? DONE : RUN;
    end
    busy_d = state_d == RUN;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      ctr_a_q <= '0;
      ctr_b_q <= '0;
      z_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      ctr_a_q <= ctr_a_d;
      ctr_b_q <= ctr_b_d;
      z_q <= z_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.z = z_q;
endmodule

// File: tb/tb_dsc_mul_seq.sv
// tb_dsc_mul_seq: scoreboard bench for full-period, early-terminating and 10-bit multiplier instances
module tb_dsc_mul_seq;
  typedef struct {int z; int cyc; int n;} exp_t;
  logic clk, rst;
  int cyc = 0;
  int checks = 0;
  int fails = 0;
  exp_t q_f[$], q_e[$], q_w[$];
  exp_t ef, ee, ew;
  int bcf = 0, bce = 0, bcw = 0;
  dsc_mul_seq_if #(.WIDTH(4)) bf();
  dsc_mul_seq_if #(.WIDTH(4)) be();
  dsc_mul_seq_if #(.WIDTH(10)) bw();
  dsc_mul_seq #(.WIDTH(4), .EARLY_TERM(0)) dut_f (.clk(clk), .rst(rst), .bus(bf));
  dsc_mul_seq #(.WIDTH(4), .EARLY_TERM(1)) dut_e (.clk(clk), .rst(rst), .bus(be));
  dsc_mul_seq #(.WIDTH(10), .EARLY_TERM(1)) dut_w (.clk(clk), .rst(rst), .bus(bw));
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic cmp(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask
  task automatic unexpected(input string nm);
    checks++;
    fails++;
    $display("FAIL %s got=done expected=no_done (cycle %0d)", nm, cyc);
  endtask
  always @(negedge clk) begin
    if (bf.done) begin
      if (q_f.size() == 0) unexpected("f_done");
      else begin
        ef = q_f.pop_front();
        cmp("f_z", int'(bf.z), ef.z);
        cmp("f_done_cycle", cyc, ef.cyc);
        cmp("f_busy_len", bcf, ef.n);
      end
      bcf = 0;
    end else bcf = bf.busy ? bcf + 1 : 0;
  end
  always @(negedge clk) begin
    if (be.done) begin
      if (q_e.size() == 0) unexpected("e_done");
      else begin
        ee = q_e.pop_front();
        cmp("e_z", int'(be.z), ee.z);
        cmp("e_done_cycle", cyc, ee.cyc);
        cmp("e_busy_len", bce, ee.n);
      end
      bce = 0;
    end else bce = be.busy ? bce + 1 : 0;
  end
  always @(negedge clk) begin
    if (bw.done) begin
      if (q_w.size() == 0) unexpected("w_done");
      else begin
        ew = q_w.pop_front();
        cmp("w_z", int'(bw.z), ew.z);
        cmp("w_done_cycle", cyc, ew.cyc);
        cmp("w_busy_len", bcw, ew.n);
      end
      bcw = 0;
    end else bcw = bw.busy ? bcw + 1 : 0;
  end
  function automatic int qs(input int w);
    return w == 0 ? q_f.size() : w == 1 ? q_e.size() : q_w.size();
  endfunction
  task automatic drain(input int w, input int budget);
    int n = 0;
    while (qs(w) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (qs(w) != 0) begin
      checks++;
      fails++;
      $display("FAIL drain_%0d timeout pending=%0d expected=0", w, qs(w));
    end
  endtask
  // expected latency comes from the operand values alone: a full 2^(2W) sweep or b whole A periods
  task automatic go_f(input int a, input int b);
    @(negedge clk);
    bf.a = 4'(a);
    bf.b = 4'(b);
    bf.start = 1;
    q_f.push_back('{z: a * b, cyc: cyc + 1 + 256, n: 256});
    @(negedge clk);
    bf.start = 0;
  endtask
  task automatic go_e(input int a, input int b);
    @(negedge clk);
    be.a = 4'(a);
    be.b = 4'(b);
    be.start = 1;
    q_e.push_back('{z: a * b, cyc: cyc + 1 + b * 16, n: b * 16});
    @(negedge clk);
    be.start = 0;
  endtask
  task automatic go_w(input int a, input int b);
    @(negedge clk);
    bw.a = 10'(a);
    bw.b = 10'(b);
    bw.start = 1;
    q_w.push_back('{z: a * b, cyc: cyc + 1 + b * 1024, n: b * 1024});
    @(negedge clk);
    bw.start = 0;
  endtask
  initial begin
    int c, ra, rb;
    rst = 1;
    {bf.start, bf.abort, bf.a, bf.b} = '0;
    {be.start, be.abort, be.a, be.b} = '0;
    {bw.start, bw.abort, bw.a, bw.b} = '0;
    repeat (3) @(negedge clk);
    cmp("rst_busy", int'(bf.busy), 0);
    cmp("rst_done", int'(bf.done), 0);
    cmp("rst_z_f", int'(bf.z), 0);
    cmp("rst_z_e", int'(be.z), 0);
    cmp("rst_z_w", int'(bw.z), 0);
    rst = 0;
    go_f(15, 15);
    drain(0, 300);
    repeat (3) @(negedge clk);
    cmp("z_hold", int'(bf.z), 225);
    go_f(0, 9);
    drain(0, 300);
    go_f(7, 0);
    drain(0, 300);
    go_e(10, 3);
    drain(1, 100);
    go_e(5, 0);
    drain(1, 20);
    go_e(15, 15);
    drain(1, 300);
    go_f(5, 6);
    repeat (20) @(negedge clk);
    bf.a = 15;
    bf.b = 15;
    bf.start = 1;
    @(negedge clk);
    bf.start = 0;
    drain(0, 300);
    @(negedge clk);
    c = cyc;
    be.a = 3;
    be.b = 2;
    be.start = 1;
    q_e.push_back('{z: 6, cyc: c + 1 + 32, n: 32});
    q_e.push_back('{z: 7, cyc: c + 1 + 32 + 1 + 16, n: 16});
    @(negedge clk);
    be.a = 7;
    be.b = 1;
    repeat (32) @(negedge clk);
    @(negedge clk);
    be.start = 0;
    drain(1, 100);
    @(negedge clk);
    bf.a = 15;
    bf.b = 15;
    bf.start = 1;
    @(negedge clk);
    bf.start = 0;
    repeat (99) @(negedge clk);
    cmp("pre_abort_busy", int'(bf.busy), 1);
    bf.abort = 1;
    bf.start = 1;
    @(negedge clk);
    bf.abort = 0;
    bf.start = 0;
    cmp("abort_busy", int'(bf.busy), 0);
    cmp("abort_z", int'(bf.z), 0);
    cmp("abort_done", int'(bf.done), 0);
    repeat (300) @(negedge clk);
    bf.a = 9;
    bf.b = 9;
    bf.start = 1;
    @(negedge clk);
    bf.start = 0;
    repeat (50) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    cmp("midrst_busy", int'(bf.busy), 0);
    cmp("midrst_done", int'(bf.done), 0);
    cmp("midrst_z", int'(bf.z), 0);
    repeat (300) @(negedge clk);
    go_f(3, 4);
    drain(0, 300);
    for (int i = 0; i < 20; i++) begin
      ra = int'($urandom_range(0, 1023));
      rb = int'($urandom_range(0, 2));
      go_w(ra, rb);
      drain(2, rb * 1024 + 50);
    end
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
